// File: rtl/odd_seq_checker.sv
// odd_seq_checker: locks onto an arithmetic stream of odd values and reports
// mismatches and 8-bit wrap-arounds observed while locked.
module odd_seq_checker #(
    parameter int STEP     = 2,
    parameter int LOCK_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] cntr_in,
    input  logic       clr,
    output logic       locked,
    output logic       err_flag,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt,
    output logic [7:0] bad_val,
    output logic [7:0] exp_val
);
    localparam logic [7:0] STEP8 = 8'(STEP);
    localparam logic [3:0] LOCK4 = 4'(LOCK_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        SYNC   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_exp;
    logic [3:0] r_match_cnt;
    logic       r_locked;
    logic       r_err_flag;
    logic [7:0] r_err_cnt;
    logic [7:0] r_wrap_cnt;
    logic [7:0] r_bad_val;
    logic [7:0] r_exp_val;

    logic [8:0] w_exp_sum;
    logic [7:0] w_reload;
    logic       w_match;
    logic [3:0] w_match_inc;
    logic [7:0] w_err_base;
    logic [7:0] w_err_next;
    logic [7:0] w_wrap_base;
    logic       w_capture;

    // Next-value helpers; the *_base terms let a coincident clr apply before a new event.
    always_comb begin
        w_exp_sum   = {1'b0, r_exp} + {1'b0, STEP8};
        w_reload    = cntr_in + STEP8;
        w_match     = (cntr_in == r_exp);
        w_match_inc = r_match_cnt + 4'd1;
        w_err_base  = clr ? 8'd0 : r_err_cnt;
        w_err_next  = (w_err_base == 8'hFF) ? 8'hFF : (w_err_base + 8'd1);
        w_wrap_base = clr ? 8'd0 : r_wrap_cnt;
        w_capture   = clr | ~r_err_flag;
    end

    // Tracker FSM and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_exp       <= 8'd0;
            r_match_cnt <= 4'd0;
            r_locked    <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_wrap_cnt  <= 8'd0;
            r_bad_val   <= 8'd0;
            r_exp_val   <= 8'd0;
        end else begin
            if (clr) begin
                r_err_flag <= 1'b0;
                r_err_cnt  <= 8'd0;
                r_wrap_cnt <= 8'd0;
                r_bad_val  <= 8'd0;
                r_exp_val  <= 8'd0;
            end
            if (en) begin
                case (r_state)
                    IDLE, ACQ: begin
                        if (cntr_in[0]) begin
                            r_exp       <= w_reload;
                            r_match_cnt <= 4'd1;
                            r_state     <= SYNC;
                        end else begin
                            r_state <= ACQ;
                        end
                    end
                    SYNC: begin
                        if (w_match) begin
                            r_exp       <= w_exp_sum[7:0];
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == LOCK4) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (cntr_in[0]) begin
                            r_exp       <= w_reload;
                            r_match_cnt <= 4'd1;
                        end else begin
                            r_state <= ACQ;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_exp <= w_exp_sum[7:0];
                            if (w_exp_sum[8]) begin
                                r_wrap_cnt <= w_wrap_base + 8'd1;
                            end
                        end else begin
                            r_locked   <= 1'b0;
                            r_err_flag <= 1'b1;
                            r_err_cnt  <= w_err_next;
                            if (w_capture) begin
                                r_bad_val <= cntr_in;
                                r_exp_val <= r_exp;
                            end
                            // Resynchronise exactly as SYNC would on a mismatch.
                            if (cntr_in[0]) begin
                                r_exp       <= w_reload;
                                r_match_cnt <= 4'd1;
                                r_state     <= SYNC;
                            end else begin
                                r_state <= ACQ;
                            end
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked   = r_locked;
    assign err_flag = r_err_flag;
    assign err_cnt  = r_err_cnt;
    assign wrap_cnt = r_wrap_cnt;
    assign bad_val  = r_bad_val;
    assign exp_val  = r_exp_val;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: a run-length reference model predicts
// outputs per edge; a monitor pops predictions and compares after each edge.
module tb_odd_seq_checker;
    localparam int STEP     = 2;
    localparam int LOCK_LEN = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] cntr_in;
    logic       clr;
    logic       locked;
    logic       err_flag;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [7:0] bad_val;
    logic [7:0] exp_val;

    odd_seq_checker #(.STEP(STEP), .LOCK_LEN(LOCK_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .cntr_in(cntr_in), .clr(clr),
        .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt),
        .wrap_cnt(wrap_cnt), .bad_val(bad_val), .exp_val(exp_val)
    );

    typedef struct {
        int lk;
        int ef;
        int ec;
        int wc;
        int bv;
        int ev;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: length of the current run of correctly spaced odd values.
    int m_run, m_nxt, m_ef, m_ec, m_wc, m_bv, m_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_nxt = 0; m_ef = 0; m_ec = 0; m_wc = 0; m_bv = 0; m_ev = 0;
    endfunction

    function automatic void model_step(input bit e, input bit c, input int v);
        bit lk;
        if (c) begin
            m_ef = 0; m_ec = 0; m_wc = 0; m_bv = 0; m_ev = 0;
        end
        if (e) begin
            lk = (m_run >= LOCK_LEN);
            if (m_run > 0 && v == m_nxt) begin
                if (lk && (m_nxt + STEP) > 255) m_wc = (m_wc + 1) % 256;
                if (m_run < LOCK_LEN) m_run++;
                m_nxt = (m_nxt + STEP) % 256;
            end else begin
                if (lk) begin
                    if (m_ef == 0) begin
                        m_bv = v;
                        m_ev = m_nxt;
                    end
                    m_ef = 1;
                    if (m_ec < 255) m_ec++;
                end
                if (v % 2 == 1) begin
                    m_run = 1;
                    m_nxt = (v + STEP) % 256;
                end else begin
                    m_run = 0;
                end
            end
        end
    endfunction

    // Monitor: compare the oldest prediction with the DUT just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",   int'(locked),   e.lk);
                chk("err_flag", int'(err_flag), e.ef);
                chk("err_cnt",  int'(err_cnt),  e.ec);
                chk("wrap_cnt", int'(wrap_cnt), e.wc);
                chk("bad_val",  int'(bad_val),  e.bv);
                chk("exp_val",  int'(exp_val),  e.ev);
            end
        end
    end

    task automatic step(input bit e, input bit c, input int v);
        exp_t x;
        @(negedge clk);
        en      = e;
        clr     = c;
        cntr_in = 8'(v);
        model_step(e, c, v);
        x.lk = (m_run >= LOCK_LEN) ? 1 : 0;
        x.ef = m_ef; x.ec = m_ec; x.wc = m_wc; x.bv = m_bv; x.ev = m_ev;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges; outputs must clear before any further edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        model_reset();
        #1;
        chk("rst_locked",   int'(locked),   0);
        chk("rst_err_flag", int'(err_flag), 0);
        chk("rst_err_cnt",  int'(err_cnt),  0);
        chk("rst_wrap_cnt", int'(wrap_cnt), 0);
        chk("rst_bad_val",  int'(bad_val),  0);
        chk("rst_exp_val",  int'(exp_val),  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int gen;
        rst = 1'b1; en = 1'b0; clr = 1'b0; cntr_in = 8'd0;
        model_reset();
        async_reset();

        // Clean stream
        step(1, 0, 1); step(1, 0, 3);
        chk("clean_not_yet_locked", int'(locked), 0);
        step(1, 0, 5);
        chk("clean_locked", int'(locked), 1);
        step(1, 0, 7);
        chk("clean_err_cnt", int'(err_cnt), 0);

        // Wrap while locked
        async_reset();
        step(1, 0, 249); step(1, 0, 251); step(1, 0, 253);
        step(1, 0, 255); step(1, 0, 1); step(1, 0, 3);
        chk("wrap_cnt", int'(wrap_cnt), 1);
        chk("wrap_err_flag", int'(err_flag), 0);
        chk("wrap_locked", int'(locked), 1);

        // Glitch and relock
        async_reset();
        step(1, 0, 9); step(1, 0, 11); step(1, 0, 13); step(1, 0, 40);
        chk("glitch_err_cnt", int'(err_cnt), 1);
        chk("glitch_bad_val", int'(bad_val), 40);
        chk("glitch_exp_val", int'(exp_val), 15);
        chk("glitch_unlocked", int'(locked), 0);
        step(1, 0, 17); step(1, 0, 19); step(1, 0, 21);
        chk("glitch_relocked", int'(locked), 1);

        // Saturation over 300 lock/mismatch cycles
        async_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 1); step(1, 0, 3); step(1, 0, 5); step(1, 0, 100);
        end
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_bad_val", int'(bad_val), 100);
        chk("sat_exp_val", int'(exp_val), 7);

        // en gating, clr, clr coincident with an in-lock mismatch
        async_reset();
        step(1, 0, 1); step(1, 0, 3); step(1, 0, 5); step(1, 0, 8);
        step(1, 0, 1); step(1, 0, 3); step(1, 0, 5);
        for (int i = 0; i < 5; i++) step(0, 0, int'($urandom_range(0, 255)));
        chk("gate_locked", int'(locked), 1);
        chk("gate_err_cnt", int'(err_cnt), 1);
        step(0, 1, 0);
        chk("clr_err_cnt", int'(err_cnt), 0);
        chk("clr_locked", int'(locked), 1);
        step(1, 1, 50);
        chk("clr_mis_err_cnt", int'(err_cnt), 1);
        chk("clr_mis_bad_val", int'(bad_val), 50);
        chk("clr_mis_exp_val", int'(exp_val), 7);

        // Lock, then reset between edges
        step(1, 0, 1); step(1, 0, 3); step(1, 0, 5);
        async_reset();

        // Randomised stream: mostly well-formed, with glitches, gaps and clears
        gen = 2 * int'($urandom_range(0, 127)) + 1;
        for (int i = 0; i < 4000; i++) begin
            bit e, c;
            int v;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 99) < 82) ? gen : int'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) gen = 2 * int'($urandom_range(0, 127)) + 1;
            step(e, c, v);
            if (e) gen = (gen + STEP) % 256;
            if (i % 997 == 996) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/odd_seq_checker.md
ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

Interface
REQ-001 SHALL have parameter STEP, default 2, expected increment between consecutive samples, modulo 256.
REQ-002 SHALL have parameter LOCK_LEN, default 3, consecutive matching samples (including the first) required to declare lock; legal range 2..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  sample enable; cntr_in is sampled only on edges where en=1.
REQ-006 SHALL have port cntr_in  input  8  value stream from the upstream odd counter (cntr_out).
REQ-007 SHALL have port clr  input  1  synchronous clear of the statistics outputs.
REQ-008 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-009 SHALL have port err_flag  output  1  sticky error indication.
REQ-010 SHALL have port err_cnt  output  8  count of in-lock mismatches, saturating at 255.
REQ-011 SHALL have port wrap_cnt  output  8  count of in-lock wrap-arounds, modulo 256.
REQ-012 SHALL have port bad_val  output  8  received value of the first error since reset/clr.
REQ-013 SHALL have port exp_val  output  8  expected value at the first error since reset/clr.

Function
REQ-014 SHALL implement FSM states IDLE, ACQ, SYNC, LOCKED; all outputs registered, no combinational path input->output.
REQ-015 SHALL hold all state and outputs unchanged on any edge with en=0 (except clr handling, REQ-024).
REQ-016 IDLE: first edge with en=1 moves to ACQ and processes that sample as ACQ does.
REQ-017 ACQ: sample with cntr_in[0]=1 -> exp <= cntr_in+STEP (8-bit wrap), match_cnt <= 1, go SYNC; even sample -> stay ACQ, no other effect.
REQ-018 SYNC: cntr_in==exp -> exp <= exp+STEP, match_cnt+1; when match_cnt+1 reaches LOCK_LEN go LOCKED on the same edge.
REQ-019 SYNC mismatch: odd sample -> reload exp <= cntr_in+STEP, match_cnt <= 1, stay SYNC; even sample -> go ACQ; no error counting outside LOCKED.
REQ-020 LOCKED match: exp <= exp+STEP; if the 9-bit sum exp+STEP overflows 255 -> wrap_cnt+1 (e.g. sample 255 with STEP=2 -> next exp 1, wrap counted).
REQ-021 LOCKED mismatch (including any even value): err_flag <= 1, err_cnt+1 saturating at 255, capture bad_val<=cntr_in and exp_val<=exp only if err_flag was 0, then resync per REQ-019 (odd -> SYNC, even -> ACQ).
REQ-022 locked SHALL rise on the edge completing LOCK_LEN matches and fall on the edge processing the first mismatch.
REQ-023 Latency: effect of a sample visible on outputs immediately after the edge that samples it (1 clock).
REQ-024 clr=1 on an edge: err_flag, err_cnt, wrap_cnt, bad_val, exp_val <= 0 regardless of en; FSM, exp, match_cnt unaffected.
REQ-025 clr coincident with a LOCKED mismatch: clear applies first, then the error -> err_flag=1, err_cnt=1, bad_val/exp_val capture the new error.
REQ-026 clr coincident with a LOCKED wrap: wrap_cnt=1 after the edge.

Reset
REQ-027 rst=1 SHALL immediately (without clock) force state IDLE, exp=0, match_cnt=0, and all outputs (locked, err_flag, err_cnt, wrap_cnt, bad_val, exp_val) to 0.
REQ-028 Reset asserted mid-stream SHALL discard lock; after release, lock requires LOCK_LEN fresh matches.

Verification
REQ-029 Clean stream: rst pulse, en=1, cntr_in 1,3,5,7 one per cycle -> locked=1 after 3rd sample edge, err_cnt=0.
REQ-030 Wrap: locked stream ...,253,255,1,3 -> wrap_cnt=1, err_flag=0, locked stays 1.
REQ-031 Glitch: locked on 11,13, then 40, then 17,19,21 -> err_flag=1, err_cnt=1, bad_val=40, exp_val=15, locked falls at 40 (ACQ), relocks after 21.
REQ-032 Saturation: 300 alternating mismatches while cycling lock -> err_cnt=255, bad_val/exp_val still hold the first error.
REQ-033 clr and en gating: en=0 for 5 cycles mid-stream -> no output change; clr pulse -> stats 0, locked unchanged; clr with mismatch -> err_cnt=1.
REQ-034 Async reset: rst asserted between edges while locked -> locked=0 and counts=0 before the next clk edge.
